// File: rtl/multiplicador_pkg.sv
// Shared definitions for the parametrised shift-add multiplier: FSM encodings,
// the legal digit-width check and a constant clog2.
`ifndef MULTIPLICADOR_PKG_SV
`define MULTIPLICADOR_PKG_SV

`define MULT_BPC_LEGAL(bpc) (((bpc) == 1) || ((bpc) == 2) || ((bpc) == 4))

package multiplicador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

`endif

// File: rtl/multiplicador_paso.sv
// One multiply step: adds the multiplicand scaled by the current multiplier digit.
module multiplicador_paso #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [BPC-1:0]     digit,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next_c
);

  localparam int unsigned PW = 2 * WIDTH;

  always_comb begin
    acc_next_c = acc + mcand * PW'(digit);
  end

endmodule

// File: rtl/multiplicador_param.sv
// Sequential multiplier retiring BPC multiplier bits per cycle, with signed mode,
// early exit on an exhausted multiplier and a valid/ack handshake.
module multiplicador_param
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               valid_data,
  input  logic               ack,
  output logic [2*WIDTH-1:0] producto,
  output logic               Done_Flag,
  output logic               busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned N     = WIDTH / BPC;
  localparam int unsigned CNT_W = clog2(N + 1);

  if (!(`MULT_BPC_LEGAL(BPC)) || ((WIDTH % BPC) != 0) || (WIDTH < 4)) begin : g_bad_cfg
    $error("multiplicador_param: illegal WIDTH/BPC combination");
  end

  state_t           state, state_nxt;
  logic [PW-1:0]    acc, acc_nxt, acc_step;
  logic [PW-1:0]    mcand, mcand_nxt;
  logic [WIDTH-1:0] mreg, mreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             neg, neg_nxt;
  logic [PW-1:0]    prod_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] a_mag, b_mag;

  multiplicador_paso #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_paso (
    .mcand      (mcand),
    .digit      (mreg[BPC-1:0]),
    .acc        (acc),
    .acc_next_c (acc_step)
  );

  // Next-state, datapath and output logic.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mcand_nxt = mcand;
    mreg_nxt  = mreg;
    cnt_nxt   = cnt;
    neg_nxt   = neg;
    prod_nxt  = producto;
    done_nxt  = Done_Flag;
    a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;

    unique case (state)
      IDLE: begin
        if (valid_data) begin
          acc_nxt   = '0;
          mcand_nxt = PW'(a_mag);
          mreg_nxt  = b_mag;
          cnt_nxt   = '0;
          neg_nxt   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_nxt = CALC;
        end
      end
      CALC: begin
        // Finish as soon as no multiplier bits remain.
        if ((mreg == '0) || (cnt == CNT_W'(N))) begin
          prod_nxt  = neg ? -acc : acc;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          acc_nxt   = acc_step;
          mcand_nxt = mcand << BPC;
          mreg_nxt  = mreg >> BPC;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (ack) begin
          done_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mreg      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      producto  <= '0;
      Done_Flag <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      mcand     <= mcand_nxt;
      mreg      <= mreg_nxt;
      cnt       <= cnt_nxt;
      neg       <= neg_nxt;
      producto  <= prod_nxt;
      Done_Flag <= done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_multiplicador_param.sv
// Bench for multiplicador_param: three instances (BPC 1/2/4, WIDTH 32) checked
// against a plain-arithmetic product and latency model.
module tb_multiplicador_param;

  logic        clk;
  logic        reset;
  logic [31:0] a_in, b_in;
  logic        sm_in;
  logic        valid_v [3];
  logic        ack_v   [3];
  logic [63:0] prod_v  [3];
  logic        done_v  [3];
  logic        busy_v  [3];

  int n_vec;
  int n_bad;

  multiplicador_param #(.WIDTH(32), .BPC(1)) dut1 (
    .clk(clk), .reset(reset), .a(a_in), .b(b_in), .signed_mode(sm_in),
    .valid_data(valid_v[0]), .ack(ack_v[0]),
    .producto(prod_v[0]), .Done_Flag(done_v[0]), .busy(busy_v[0]));

  multiplicador_param #(.WIDTH(32), .BPC(2)) dut2 (
    .clk(clk), .reset(reset), .a(a_in), .b(b_in), .signed_mode(sm_in),
    .valid_data(valid_v[1]), .ack(ack_v[1]),
    .producto(prod_v[1]), .Done_Flag(done_v[1]), .busy(busy_v[1]));

  multiplicador_param #(.WIDTH(32), .BPC(4)) dut4 (
    .clk(clk), .reset(reset), .a(a_in), .b(b_in), .signed_mode(sm_in),
    .valid_data(valid_v[2]), .ack(ack_v[2]),
    .producto(prod_v[2]), .Done_Flag(done_v[2]), .busy(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sm;
    int          idx;
    int          hold;
    bit          disturb;
    logic [63:0] exp_p;
    int          exp_lat;
  } vec_t;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input bit sm);
    longint sx, sy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic int ref_lat(input logic [31:0] y, input bit sm, input int bpc);
    logic [31:0] mag;
    int len;
    mag = (sm && y[31]) ? (32'd0 - y) : y;
    len = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
    return (len + bpc - 1) / bpc + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (done_v[idx]) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full transaction from a sample point (posedge+1) back to a sample point.
  task automatic apply(input string name, input int idx, input logic [31:0] av,
                       input logic [31:0] bv, input bit sm, input int hold,
                       input bit disturb, input logic [63:0] exp_p, input int exp_lat);
    int lat;
    a_in = av; b_in = bv; sm_in = sm; valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    valid_v[idx] = 1'b0;
    check({name, "_busy_rise"}, 64'(busy_v[idx]), 64'd1);
    check({name, "_done_early"}, 64'(done_v[idx]), 64'd0);
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      if (done_v[idx] && k > 1) break;
      @(posedge clk); #1;
      if (done_v[idx]) begin
        lat = k;
        break;
      end
      if (disturb) begin
        a_in = $urandom; b_in = $urandom; sm_in = 1'($urandom);
        valid_v[idx] = 1'($urandom);
        ack_v[idx]   = 1'($urandom);
      end
    end
    valid_v[idx] = 1'b0;
    ack_v[idx]   = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_producto"}, prod_v[idx], exp_p);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({name, "_done_held"}, 64'(done_v[idx]), 64'd1);
    end
    ack_v[idx] = 1'b1;
    @(posedge clk); #1;
    ack_v[idx] = 1'b0;
    check({name, "_done_clr"}, 64'(done_v[idx]), 64'd0);
    check({name, "_busy_fall"}, 64'(busy_v[idx]), 64'd0);
    check({name, "_prod_kept"}, prod_v[idx], exp_p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [$];
    vec_t v;
    int lat;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    a_in = '0; b_in = '0; sm_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_v[i] = 1'b0;
      ack_v[i]   = 1'b0;
    end

    vecs.push_back('{32'd32, 32'd3, 1'b0, 0, 2, 1'b0, 64'd96, 3});
    vecs.push_back('{32'hFFFF_FFF9, 32'd6, 1'b1, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFD6, 4});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1, 1'b0, 64'h4000_0000_0000_0000, 33});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0, 64'hFFFF_FFFE_0000_0001, 33});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 0, 1'b0, 64'hFFFF_FFFE_0000_0001, 17});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 0, 1'b0, 64'hFFFF_FFFE_0000_0001, 9});
    vecs.push_back('{32'd12345, 32'd0, 1'b0, 0, 1, 1'b0, 64'd0, 1});
    vecs.push_back('{32'd5, 32'hFFFF_FFFD, 1'b1, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 3});
    vecs.push_back('{32'd1000, 32'd1000, 1'b0, 0, 0, 1'b1, 64'd1000000, 11});
    vecs.push_back('{32'd1000, 32'd1000, 1'b0, 2, 0, 1'b1, 64'd1000000, 4});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 0, 1'b0, 64'd1, 2});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 2, 0, 1'b0, 64'hC000_0000_8000_0000, 9});
    for (int i = 0; i < 40; i++) begin
      v.idx     = int'($urandom_range(0, 2));
      v.a       = $urandom;
      v.b       = $urandom >> $urandom_range(0, 31);
      v.sm      = 1'($urandom);
      if (v.sm && $urandom_range(0, 1) == 1) v.b = 32'd0 - v.b;
      v.hold    = int'($urandom_range(0, 3));
      v.disturb = 1'($urandom);
      v.exp_p   = ref_prod(v.a, v.b, v.sm);
      v.exp_lat = ref_lat(v.b, v.sm, 1 << v.idx);
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_prod%0d", i), prod_v[i], 64'd0);
      check($sformatf("reset_done%0d", i), 64'(done_v[i]), 64'd0);
      check($sformatf("reset_busy%0d", i), 64'(busy_v[i]), 64'd0);
    end
    #3 reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sm,
            vecs[i].hold, vecs[i].disturb, vecs[i].exp_p, vecs[i].exp_lat);

    // Back-to-back with valid_data and ack both held high.
    a_in = 32'd5; b_in = 32'd5; sm_in = 1'b0;
    valid_v[0] = 1'b1; ack_v[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, lat);
    check("b2b_first_latency", 64'(lat), 64'd4);
    check("b2b_first_producto", prod_v[0], 64'd25);
    a_in = 32'd3; b_in = 32'd9;
    @(posedge clk); #1;
    check("b2b_ack_done", 64'(done_v[0]), 64'd0);
    check("b2b_ack_busy", 64'(busy_v[0]), 64'd0);
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    check("b2b_recapture_busy", 64'(busy_v[0]), 64'd1);
    wait_done(0, lat);
    check("b2b_second_latency", 64'(lat), 64'd5);
    check("b2b_second_producto", prod_v[0], 64'd27);
    @(posedge clk); #1;
    ack_v[0] = 1'b0;
    check("b2b_second_busy_fall", 64'(busy_v[0]), 64'd0);

    // Reset in the middle of CALC.
    a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; sm_in = 1'b0; valid_v[0] = 1'b1;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_calc_prod", prod_v[0], 64'd0);
    check("rst_calc_done", 64'(done_v[0]), 64'd0);
    check("rst_calc_busy", 64'(busy_v[0]), 64'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    apply("after_rst_calc", 0, 32'd7, 32'd9, 1'b0, 0, 1'b0, 64'd63, 5);

    // Reset while waiting in DONE.
    a_in = 32'd11; b_in = 32'd13; sm_in = 1'b0; valid_v[0] = 1'b1;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    wait_done(0, lat);
    check("rst_done_pre_prod", prod_v[0], 64'd143);
    #2 reset = 1'b0;
    #1;
    check("rst_done_prod", prod_v[0], 64'd0);
    check("rst_done_done", 64'(done_v[0]), 64'd0);
    check("rst_done_busy", 64'(busy_v[0]), 64'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    apply("after_rst_done", 0, 32'd6, 32'd7, 1'b0, 1, 1'b0, 64'd42, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplicador_param.md
# multiplicador_param

Parametrised sequential multiplier with a valid/ack handshake. It is the successor of the fixed shift-add multiplier, with these additions:
- configurable operand width;
- configurable radix, i.e. 1, 2 or 4 multiplier bits retired per cycle;
- per-transaction signed/unsigned mode;
- early termination once the remaining multiplier bits are zero.

It sits between an operand producer and a result consumer and computes one product at a time.

## Interface
- WIDTH, 32, operand width; must be a multiple of BPC, minimum 4.
- BPC, 1, multiplier bits processed per CALC cycle; legal values 1, 2, 4.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier (the shifted operand).
- signed_mode  in  1  1 = operands and result are two's complement; 0 = unsigned.
- valid_data  in  1  operands valid; sampled only in IDLE.
- ack  in  1  consumer has taken the result; sampled only in DONE.
- producto  out  2*WIDTH  product.
- Done_Flag  out  1  producto valid, held until ack.
- busy  out  1  high in CALC and DONE.

## Operation
- Reset (reset=0, asynchronous):
  - state goes to IDLE;
  - producto=0, Done_Flag=0, busy=0;
  - all internal registers cleared.
- This applies at any time, including mid-CALC or in DONE. The aborted transaction is lost and no Done_Flag is produced.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - On an edge with valid_data=1, capture |a|, |b| and a sign flag, then go to CALC.
  - The sign flag is signed_mode & (a[MSB]^b[MSB]). Magnitudes are computed only when signed_mode=1; otherwise the raw operands are used.
- CALC, evaluated each edge:
  - If the multiplier register is 0, or N=WIDTH/BPC steps are already done: producto <= sign ? -acc : acc, Done_Flag <= 1, go to DONE.
  - Otherwise: acc += mcand * mreg[BPC-1:0], mcand <<= BPC, mreg >>= BPC, step count +1.
- DONE:
  - producto and Done_Flag are held stable.
  - On an edge with ack=1, Done_Flag <= 0 and the FSM returns to IDLE.
- Arithmetic and widths:
  - acc and mcand are 2*WIDTH bits; mreg is WIDTH bits; the step counter is clog2(N+1) bits.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits unsigned in WIDTH bits. The most-negative squared is 2^(2*WIDTH-2), which fits in the result.
  - No overflow is possible.
- Ignored inputs:
  - valid_data outside IDLE; operands are not re-sampled.
  - ack outside DONE.
  - Changes to a, b and signed_mode after capture.
- producto keeps its last value after ack; it changes only at the next completion or on reset.

## Timing
- The capture edge is edge 0.
- p = number of processing steps = ceil(bitlen(|b|)/BPC), where bitlen(0)=0; p ≤ N.
- Done_Flag and the final producto become visible after edge p+1.
  - Minimum latency is 1 (b=0).
  - Maximum latency is N+1.
- busy rises after edge 0 and falls after the ack edge.
- If ack=1 at the edge that enters DONE, it is ignored; Done_Flag stays high for at least one full cycle.
- If ack is held high, DONE lasts exactly 1 cycle.
- If valid_data=1 in the cycle right after the ack edge, a new capture occurs at that edge. Throughput is therefore p+3 cycles per product.

## Structure
- Shared package multiplicador_pkg holds:
  - state encodings IDLE/CALC/DONE as localparams;
  - the legal-BPC check macro;
  - the clog2 function.
- Sub-module multiplicador_paso (combinational) takes mcand, mreg[BPC-1:0] and acc, and returns acc + mcand*digit. It is instantiated once.
- The top level holds the FSM, operand registers, step counter, sign fix-up and output registers.

## Test plan
- WIDTH=32, BPC=1, unsigned, a=32, b=3, ack asserted 23 ns after Done_Flag -> producto=96; Done_Flag after edge 3; busy falls after the ack edge.
- Same configuration, back-to-back a=5, b=5 with valid_data held high -> producto=25 at latency 4; second capture on the edge after the ack edge.
- signed_mode=1, a=-7, b=6 -> producto=0xFFFFFFFF_FFFFFFD6 (-42). Also a=0x80000000, b=0x80000000 signed -> 0x40000000_00000000 at latency 33.
- Unsigned a=b=0xFFFFFFFF -> 0xFFFFFFFE_00000001; latency 33 with BPC=1, 17 with BPC=2, 9 with BPC=4. Also b=0 -> producto=0 at latency 1.
- Reset pulled low mid-CALC, and separately in DONE -> producto=0, Done_Flag=0, busy=0 immediately. After release, a new transaction gives the correct result.
- ack pulsed during CALC, and valid_data toggled with new a/b during CALC -> both ignored; result equals the originally captured operands' product.
